// File: rtl/jpeg_cone_pipe.sv
//------------------------------------------------------------------------------
// Module  : jpeg_cone_pipe
// Brief   : Bit-parallel JPEG cone function behind an elastic valid/ready
//           pipeline, with an optional per-frame XOR checksum mode.
//           Optional macro JPEG_CONE_PARITY_EN adds out_parity.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jpeg_cone_pipe #(
  parameter int W         = 8,
  parameter int STAGES    = 2,
  parameter int FRAME_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  input  logic [W-1:0] in_e,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
`ifdef JPEG_CONE_PARITY_EN
  ,output logic        out_parity
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int T  = STAGES - 1;

  logic [W-1:0] f_in;
  assign f_in = (in_c & in_d & ~in_a) ^ (in_a | ~in_e) ^ in_b;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          accept, first_in, last_in, tag_in;

  assign accept   = in_valid & in_ready;
  assign first_in = (cnt_q == '0);
  assign last_in  = (cnt_q == CW'(FRAME_LEN - 1));
  // A beat opening a frame carries the live mode; later beats use the latched one.
  assign tag_in   = first_in ? mode : mode_q;

  logic [STAGES-1:0] v_q, l_q, m_q, adv, load;
  logic [STAGES-1:0] up_v, up_l, up_m;
  logic [W-1:0]      f_q  [STAGES];
  logic [W-1:0]      up_f [STAGES];
`ifdef JPEG_CONE_PARITY_EN
  logic [STAGES-1:0] p_q, up_p;
`endif

  logic         hold_q, hold_d;
  logic [W-1:0] hold_data_q, hold_data_d;
  logic [W-1:0] acc_q, acc_d;
`ifdef JPEG_CONE_PARITY_EN
  logic         hold_par_q, hold_par_d;
`endif

  logic         tail_v, tail_l, tail_m, tail_take, consume;
  logic [W-1:0] tail_f;

  assign tail_v = v_q[T];
  assign tail_l = l_q[T];
  assign tail_m = m_q[T];
  assign tail_f = f_q[T];

  // Checksum beats may enter as the hold drains; per-beat results wait behind it.
  always_comb begin
    tail_take = 1'b0;
    if (tail_m) tail_take = ~hold_q | out_ready;
    else        tail_take = ~hold_q & out_ready;
  end

  always_comb begin
    adv    = '0;
    adv[T] = tail_v & tail_take;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign load     = ~v_q | adv;
  assign in_ready = ~rst & load[0];
  assign consume  = adv[T] & tail_m;

  always_comb begin
    up_v[0] = accept;
    up_l[0] = last_in;
    up_m[0] = tag_in;
    up_f[0] = f_in;
`ifdef JPEG_CONE_PARITY_EN
    up_p[0] = ^f_in;
`endif
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = adv[k-1];
      up_l[k] = l_q[k-1];
      up_m[k] = m_q[k-1];
      up_f[k] = f_q[k-1];
`ifdef JPEG_CONE_PARITY_EN
      up_p[k] = p_q[k-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      l_q <= '0;
      m_q <= '0;
`ifdef JPEG_CONE_PARITY_EN
      p_q <= '0;
`endif
      for (int k = 0; k < STAGES; k++) f_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= up_v[k];
          l_q[k] <= up_l[k];
          m_q[k] <= up_m[k];
          f_q[k] <= up_f[k];
`ifdef JPEG_CONE_PARITY_EN
          p_q[k] <= up_p[k];
`endif
        end
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (accept) begin
      cnt_d = last_in ? '0 : cnt_q + CW'(1);
      if (first_in) mode_d = mode;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
`ifdef JPEG_CONE_PARITY_EN
    hold_par_d  = hold_par_q;
`endif
    if (hold_q & out_ready) hold_d = 1'b0;
    if (consume) begin
      if (tail_l) begin
        hold_data_d = acc_q ^ tail_f;
        hold_d      = 1'b1;
        acc_d       = '0;
`ifdef JPEG_CONE_PARITY_EN
        hold_par_d  = ^(acc_q ^ tail_f);
`endif
      end else begin
        acc_d = acc_q ^ tail_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
`ifdef JPEG_CONE_PARITY_EN
      hold_par_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
`ifdef JPEG_CONE_PARITY_EN
      hold_par_q  <= hold_par_d;
`endif
    end
  end

  logic beat_out;
  assign beat_out  = tail_v & ~tail_m;
  assign out_valid = hold_q | beat_out;
  assign out_data  = hold_q ? hold_data_q : (beat_out ? tail_f : '0);
  assign out_last  = hold_q | (beat_out & tail_l);
`ifdef JPEG_CONE_PARITY_EN
  assign out_parity = hold_q ? hold_par_q : (beat_out & p_q[T]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_jpeg_cone_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_jpeg_cone_pipe
// Brief   : Self-checking bench for jpeg_cone_pipe (W=8, STAGES=2, FRAME_LEN=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jpeg_cone_pipe;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int FL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0, in_e = '0;
  logic         in_ready, out_valid, out_last;
  logic [W-1:0] out_data;
`ifdef JPEG_CONE_PARITY_EN
  logic         out_parity;
`endif

  jpeg_cone_pipe #(.W(W), .STAGES(ST), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
`ifdef JPEG_CONE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, c, d, e;
    logic [7:0] f;
    logic       last;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  vec_t vecs [5];
  exp_t q [$];

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_out = 0;
  logic [7:0] last_out = '0;
  bit         rand_done = 0;

  // Transaction-level reference state
  int         pos = 0;
  logic       fmode = 1'b0;
  logic [7:0] macc = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  function automatic logic [7:0] cone(input logic [7:0] a, b, c, d, e);
    return (c & d & ~a) ^ (a | ~e) ^ b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pos = 0;
      macc = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'b0, out_valid}, 1);
        chk("stall_data", {24'b0, out_data}, {24'b0, prev_data});
        chk("stall_last", {31'b0, out_last}, {31'b0, prev_last});
      end
      if (in_valid && in_ready) begin
        logic [7:0] f;
        logic       lst;
        if (pos == 0) fmode = mode;
        f   = cone(in_a, in_b, in_c, in_d, in_e);
        lst = (pos == FL - 1);
        if (!fmode) q.push_back('{data: f, last: lst});
        else begin
          macc ^= f;
          if (lst) begin
            q.push_back('{data: macc, last: 1'b1});
            macc = '0;
          end
        end
        pos = lst ? 0 : pos + 1;
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, want no output", out_data);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("sb_data", {24'b0, out_data}, {24'b0, x.data});
          chk("sb_last", {31'b0, out_last}, {31'b0, x.last});
`ifdef JPEG_CONE_PARITY_EN
          chk("sb_parity", {31'b0, out_parity}, {31'b0, ^x.data});
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic do_reset(input bit check);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_last", {31'b0, out_last}, 0);
      chk("rst_out_data", {24'b0, out_data}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
    end
    rst = 1'b0;
    #1;
    if (check) chk("post_rst_in_ready", {31'b0, in_ready}, 1);
  endtask

  task automatic send(input logic [7:0] a, b, c, d, e, input logic m);
    bit ok = 0;
    in_a = a; in_b = b; in_c = c; in_d = d; in_e = e;
    mode = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no in_ready, want accept within 200 cycles");
    end
  endtask

  // a=c=d=0, e=FF makes the cone output equal to b
  task automatic send_f(input logic [7:0] f, input logic m);
    send(8'h00, f, 8'h00, 8'h00, 8'hFF, m);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int base;
    vecs[0] = '{a: 8'h0F, b: 8'h3C, c: 8'hFF, d: 8'hFF, e: 8'hFF, f: 8'hC3, last: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h00, c: 8'h00, d: 8'h00, e: 8'h00, f: 8'hFF, last: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'h00, c: 8'h00, d: 8'h00, e: 8'h00, f: 8'hFF, last: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'hFF, c: 8'hFF, d: 8'hFF, e: 8'hFF, f: 8'h00, last: 1'b1};
    vecs[4] = '{a: 8'hAA, b: 8'h00, c: 8'hFF, d: 8'h0F, e: 8'hF0, f: 8'hAA, last: 1'b0};

    do_reset(1);

    // Mode 0 function and latency
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_c = vecs[i].c;
      in_d = vecs[i].d; in_e = vecs[i].e; mode = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (ST - 1) begin
        chk("vec_early_valid", {31'b0, out_valid}, 0);
        @(posedge clk);
        #1;
      end
      chk("vec_valid", {31'b0, out_valid}, 1);
      chk("vec_data", {24'b0, out_data}, {24'b0, vecs[i].f});
      chk("vec_last", {31'b0, out_last}, {31'b0, vecs[i].last});
      @(posedge clk);
      #1;
    end

    // Backpressure: pipeline fills with ST beats, then in_ready drops
    do_reset(0);
    base = n_out;
    out_ready = 1'b0;
    send_f(8'h11, 1'b0);
    send_f(8'h22, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_data", {24'b0, out_data}, 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_f(8'h33, 1'b0);
    send_f(8'h44, 1'b0);
    send_f(8'h55, 1'b0);
    send_f(8'h66, 1'b0);
    drain();
    chk("bp_count", n_out - base, 6);

    // Mode 1 checksum
    do_reset(0);
    base = n_out;
    send_f(8'h01, 1'b1);
    send_f(8'h02, 1'b1);
    send_f(8'h04, 1'b1);
    send_f(8'h08, 1'b1);
    drain();
    chk("m1_count", n_out - base, 1);
    chk("m1_checksum", {24'b0, last_out}, 32'h0F);

    // Mode change mid-frame takes effect at the next frame
    do_reset(0);
    base = n_out;
    send_f(8'hA1, 1'b0);
    send_f(8'hA2, 1'b0);
    send_f(8'hA3, 1'b1);
    send_f(8'hA4, 1'b1);
    send_f(8'h01, 1'b1);
    send_f(8'h10, 1'b1);
    send_f(8'h20, 1'b1);
    send_f(8'h40, 1'b1);
    drain();
    chk("switch_count", n_out - base, 5);
    chk("switch_checksum", {24'b0, last_out}, 32'h71);

    // Reset mid-frame drops the partial checksum
    do_reset(0);
    base = n_out;
    send_f(8'h5A, 1'b1);
    send_f(8'h3C, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    send_f(8'hFF, 1'b1);
    send_f(8'h00, 1'b1);
    send_f(8'h0F, 1'b1);
    send_f(8'hF0, 1'b1);
    drain();
    chk("midrst_count", n_out - base, 1);
    chk("midrst_checksum", {24'b0, last_out}, 32'h00);

    // Randomised traffic with random backpressure and mode changes
    do_reset(0);
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom, $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
